// File: rtl/cpu_pkg.sv
// Shared definitions for the 8-bit bus CPU control path:
// opcodes, T-states and the control-word bit layout.
package cpu_pkg;

  localparam int STEP_W = 3;
  localparam int OP_W   = 4;

  localparam logic [3:0] OP_NOP = 4'h0;
  localparam logic [3:0] OP_LDA = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_SUB = 4'h3;
  localparam logic [3:0] OP_STA = 4'h4;
  localparam logic [3:0] OP_LDI = 4'h5;
  localparam logic [3:0] OP_JMP = 4'h6;
  localparam logic [3:0] OP_JC  = 4'h7;
  localparam logic [3:0] OP_JZ  = 4'h8;
  localparam logic [3:0] OP_OUT = 4'hE;
  localparam logic [3:0] OP_HLT = 4'hF;

  localparam logic [2:0] T0 = 3'd0;
  localparam logic [2:0] T1 = 3'd1;
  localparam logic [2:0] T2 = 3'd2;
  localparam logic [2:0] T3 = 3'd3;
  localparam logic [2:0] T4 = 3'd4;

  localparam int CW_PC_EN     = 0;
  localparam int CW_PC_INC    = 1;
  localparam int CW_PC_LATCH  = 2;
  localparam int CW_MAR_LATCH = 3;
  localparam int CW_RAM_EN    = 4;
  localparam int CW_RAM_LATCH = 5;
  localparam int CW_IR_EN     = 6;
  localparam int CW_IR_LATCH  = 7;
  localparam int CW_A_EN      = 8;
  localparam int CW_A_LATCH   = 9;
  localparam int CW_B_LATCH   = 10;
  localparam int CW_ALU_EN    = 11;
  localparam int CW_ALU_SUB   = 12;
  localparam int CW_FLAGS     = 13;
  localparam int CW_OUT_LATCH = 14;
  // Not a bus strobe: tells the sequencer to set halted.
  localparam int CW_HLT       = 15;

  typedef logic [15:0] ctrl_word_t;

  function automatic ctrl_word_t cw(input int b);
    ctrl_word_t w;
    w = '0;
    w[b] = 1'b1;
    return w;
  endfunction

endpackage

// File: rtl/microcode_rom.sv
// Combinational microcode: (opcode, step, flags) -> control word
// plus a flag marking the final T-state of the instruction.
module microcode_rom
  import cpu_pkg::*;
#(
  parameter int STEP_W_P = 3,
  parameter int OP_W_P   = 4
) (
  input  logic [OP_W_P-1:0]   i_opcode,
  input  logic [STEP_W_P-1:0] i_step,
  input  logic                i_flag_c,
  input  logic                i_flag_z,
  output ctrl_word_t          o_ctrl,
  output logic                o_last
);

  always_comb begin
    o_ctrl = '0;
    o_last = 1'b0;
    unique case (i_step)
      T0: o_ctrl = cw(CW_PC_EN) | cw(CW_MAR_LATCH);
      T1: o_ctrl = cw(CW_RAM_EN) | cw(CW_IR_LATCH)
                 | cw(CW_PC_INC);
      T2: begin
        o_last = 1'b1;
        case (i_opcode)
          OP_LDA, OP_STA: begin
            o_ctrl = cw(CW_IR_EN) | cw(CW_MAR_LATCH);
            o_last = 1'b0;
          end
          OP_ADD, OP_SUB: begin
            o_ctrl = cw(CW_IR_EN) | cw(CW_MAR_LATCH);
            o_last = 1'b0;
          end
          OP_LDI: o_ctrl = cw(CW_IR_EN) | cw(CW_A_LATCH);
          OP_JMP: o_ctrl = cw(CW_IR_EN) | cw(CW_PC_LATCH);
          OP_JC: begin
            if (i_flag_c)
              o_ctrl = cw(CW_IR_EN) | cw(CW_PC_LATCH);
          end
          OP_JZ: begin
            if (i_flag_z)
              o_ctrl = cw(CW_IR_EN) | cw(CW_PC_LATCH);
          end
          OP_OUT: o_ctrl = cw(CW_A_EN) | cw(CW_OUT_LATCH);
          OP_HLT: o_ctrl = cw(CW_HLT);
          default: o_ctrl = '0;
        endcase
      end
      T3: begin
        o_last = 1'b1;
        case (i_opcode)
          OP_LDA: o_ctrl = cw(CW_RAM_EN) | cw(CW_A_LATCH);
          OP_ADD, OP_SUB: begin
            o_ctrl = cw(CW_RAM_EN) | cw(CW_B_LATCH);
            o_last = 1'b0;
          end
          OP_STA: o_ctrl = cw(CW_A_EN) | cw(CW_RAM_LATCH);
          default: o_ctrl = '0;
        endcase
      end
      T4: begin
        o_last = 1'b1;
        case (i_opcode)
          OP_ADD: o_ctrl = cw(CW_ALU_EN) | cw(CW_A_LATCH)
                         | cw(CW_FLAGS);
          OP_SUB: o_ctrl = cw(CW_ALU_EN) | cw(CW_A_LATCH)
                         | cw(CW_FLAGS) | cw(CW_ALU_SUB);
          default: o_ctrl = '0;
        endcase
      end
      // Unreachable steps: emit nothing, wrap to T0.
      default: begin
        o_ctrl = '0;
        o_last = 1'b1;
      end
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// T-state sequencer for the 8-bit bus CPU: step counter, halt flag
// and run/reset gating around the microcode ROM.
module control_sequencer
  import cpu_pkg::*;
#(
  parameter int STEP_W = 3,
  parameter int OP_W   = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              run,
  input  logic [OP_W-1:0]   opcode,
  input  logic              flag_c,
  input  logic              flag_z,
  output logic              pc_en,
  output logic              pc_inc,
  output logic              pc_latch,
  output logic              mar_latch,
  output logic              ram_en,
  output logic              ram_latch,
  output logic              ir_en,
  output logic              ir_latch,
  output logic              a_en,
  output logic              a_latch,
  output logic              b_latch,
  output logic              alu_en,
  output logic              alu_sub,
  output logic              flags_latch,
  output logic              out_latch,
  output logic              halted,
  output logic [STEP_W-1:0] tstate
);

  logic [STEP_W-1:0] r_step;
  logic              r_halted;
  logic [STEP_W-1:0] w_next_step;
  logic              w_next_halted;
  ctrl_word_t        w_ctrl;
  ctrl_word_t        w_out;
  logic              w_last;
  logic              w_active;

  microcode_rom #(
    .STEP_W_P (STEP_W),
    .OP_W_P   (OP_W)
  ) u_rom (
    .i_opcode (opcode),
    .i_step   (r_step),
    .i_flag_c (flag_c),
    .i_flag_z (flag_z),
    .o_ctrl   (w_ctrl),
    .o_last   (w_last)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      r_step   <= '0;
      r_halted <= 1'b0;
    end else begin
      r_step   <= w_next_step;
      r_halted <= w_next_halted;
    end
  end

  always_comb begin
    w_next_step   = r_step;
    w_next_halted = r_halted;
    if (run && !r_halted) begin
      w_next_step = w_last ? '0 : r_step + STEP_W'(1);
      if (w_ctrl[CW_HLT])
        w_next_halted = 1'b1;
    end
  end

  assign w_active = run & ~r_halted & ~reset;

  always_comb begin
    w_out = '0;
    if (w_active)
      w_out = w_ctrl;
  end

  assign pc_en       = w_out[CW_PC_EN];
  assign pc_inc      = w_out[CW_PC_INC];
  assign pc_latch    = w_out[CW_PC_LATCH];
  assign mar_latch   = w_out[CW_MAR_LATCH];
  assign ram_en      = w_out[CW_RAM_EN];
  assign ram_latch   = w_out[CW_RAM_LATCH];
  assign ir_en       = w_out[CW_IR_EN];
  assign ir_latch    = w_out[CW_IR_LATCH];
  assign a_en        = w_out[CW_A_EN];
  assign a_latch     = w_out[CW_A_LATCH];
  assign b_latch     = w_out[CW_B_LATCH];
  assign alu_en      = w_out[CW_ALU_EN];
  assign alu_sub     = w_out[CW_ALU_SUB];
  assign flags_latch = w_out[CW_FLAGS];
  assign out_latch   = w_out[CW_OUT_LATCH];
  assign halted      = r_halted;
  assign tstate      = r_step;

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: instruction-level model checked
// every cycle, plus directed literal checks.
module tb_control_sequencer;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       run = 1'b0;
  logic [3:0] opcode = 4'h5;
  logic       flag_c = 1'b0;
  logic       flag_z = 1'b0;
  logic pc_en, pc_inc, pc_latch, mar_latch, ram_en, ram_latch;
  logic ir_en, ir_latch, a_en, a_latch, b_latch, alu_en;
  logic alu_sub, flags_latch, out_latch, halted;
  logic [2:0] tstate;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  control_sequencer #(.STEP_W(3), .OP_W(4)) dut (
    .clk(clk), .reset(reset), .run(run), .opcode(opcode),
    .flag_c(flag_c), .flag_z(flag_z),
    .pc_en(pc_en), .pc_inc(pc_inc), .pc_latch(pc_latch),
    .mar_latch(mar_latch), .ram_en(ram_en),
    .ram_latch(ram_latch), .ir_en(ir_en), .ir_latch(ir_latch),
    .a_en(a_en), .a_latch(a_latch), .b_latch(b_latch),
    .alu_en(alu_en), .alu_sub(alu_sub),
    .flags_latch(flags_latch), .out_latch(out_latch),
    .halted(halted), .tstate(tstate)
  );

  // Bench-side strobe vector, MSB..LSB in this order.
  localparam logic [14:0] S_PC_EN  = 15'h4000;
  localparam logic [14:0] S_PC_INC = 15'h2000;
  localparam logic [14:0] S_PC_LAT = 15'h1000;
  localparam logic [14:0] S_MAR    = 15'h0800;
  localparam logic [14:0] S_RAM_EN = 15'h0400;
  localparam logic [14:0] S_RAM_LT = 15'h0200;
  localparam logic [14:0] S_IR_EN  = 15'h0100;
  localparam logic [14:0] S_IR_LT  = 15'h0080;
  localparam logic [14:0] S_A_EN   = 15'h0040;
  localparam logic [14:0] S_A_LT   = 15'h0020;
  localparam logic [14:0] S_B_LT   = 15'h0010;
  localparam logic [14:0] S_ALU_EN = 15'h0008;
  localparam logic [14:0] S_SUB    = 15'h0004;
  localparam logic [14:0] S_FLAGS  = 15'h0002;
  localparam logic [14:0] S_OUT    = 15'h0001;

  wire [14:0] got_vec = {pc_en, pc_inc, pc_latch, mar_latch,
    ram_en, ram_latch, ir_en, ir_latch, a_en, a_latch,
    b_latch, alu_en, alu_sub, flags_latch, out_latch};

  // Instruction length in T-states.
  function automatic int ilen(input logic [3:0] op);
    if (op == 4'h2 || op == 4'h3) return 5;
    if (op == 4'h1 || op == 4'h4) return 4;
    return 3;
  endfunction

  function automatic logic [14:0] model_vec(
    input logic [3:0] op, input int st,
    input logic c, input logic z);
    if (st == 0) return S_PC_EN | S_MAR;
    if (st == 1) return S_RAM_EN | S_IR_LT | S_PC_INC;
    if (st >= ilen(op)) return '0;
    if (st == 2) begin
      if (op inside {4'h1, 4'h2, 4'h3, 4'h4})
        return S_IR_EN | S_MAR;
      if (op == 4'h5) return S_IR_EN | S_A_LT;
      if (op == 4'h6) return S_IR_EN | S_PC_LAT;
      if (op == 4'h7) return c ? (S_IR_EN | S_PC_LAT) : '0;
      if (op == 4'h8) return z ? (S_IR_EN | S_PC_LAT) : '0;
      if (op == 4'hE) return S_A_EN | S_OUT;
      return '0;
    end
    if (st == 3) begin
      if (op == 4'h1) return S_RAM_EN | S_A_LT;
      if (op == 4'h4) return S_A_EN | S_RAM_LT;
      return S_RAM_EN | S_B_LT;
    end
    return S_ALU_EN | S_A_LT | S_FLAGS
         | ((op == 4'h3) ? S_SUB : 15'h0);
  endfunction

  int m_step = 0;
  bit m_halted = 1'b0;

  always @(posedge clk) begin
    if (reset) begin
      m_step = 0;
      m_halted = 1'b0;
    end else if (run && !m_halted) begin
      if (opcode == 4'hF && m_step == 2) m_halted = 1'b1;
      m_step = (m_step >= ilen(opcode) - 1) ? 0 : m_step + 1;
    end
  end

  task automatic check(input string nm,
                       input logic [31:0] got,
                       input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               nm, got, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    logic [14:0] e;
    e = (reset || !run || m_halted) ? 15'h0 :
        model_vec(opcode, m_step, flag_c, flag_z);
    check("model_strobes", {17'h0, got_vec}, {17'h0, e});
    check("model_tstate", {29'h0, tstate}, m_step);
    check("model_halted", {31'h0, halted}, {31'h0, m_halted});
    n_tests++;
    if ($countones({pc_en, ram_en, ir_en, a_en, alu_en}) > 1) begin
      n_fail++;
      $display("FAIL bus_invariant: drivers %b expected onehot0",
               {pc_en, ram_en, ir_en, a_en, alu_en});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic lit(input string nm, input logic [2:0] ts,
                     input logic [14:0] sv);
    check({nm, "_tstate"}, {29'h0, tstate}, {29'h0, ts});
    check({nm, "_strobes"}, {17'h0, got_vec}, {17'h0, sv});
  endtask

  localparam logic [14:0] FETCH0 = S_PC_EN | S_MAR;
  localparam logic [14:0] FETCH1 = S_RAM_EN | S_IR_LT | S_PC_INC;

  initial begin
    tick(); tick();
    lit("reset", 3'd0, 15'h0);
    check("reset_halted", {31'h0, halted}, 32'h0);
    reset = 1'b0; run = 1'b1; #1;
    // LDI
    lit("ldi_t0", 3'd0, FETCH0);
    tick(); lit("ldi_t1", 3'd1, FETCH1);
    tick(); lit("ldi_t2", 3'd2, S_IR_EN | S_A_LT);
    tick(); lit("ldi_wrap", 3'd0, FETCH0);
    // ADD then SUB
    opcode = 4'h2;
    tick(); tick();
    lit("add_t2", 3'd2, S_IR_EN | S_MAR);
    tick(); lit("add_t3", 3'd3, S_RAM_EN | S_B_LT);
    tick(); lit("add_t4", 3'd4, S_ALU_EN | S_A_LT | S_FLAGS);
    tick(); lit("add_wrap", 3'd0, FETCH0);
    opcode = 4'h3;
    for (int i = 0; i < 4; i++) tick();
    lit("sub_t4", 3'd4, S_ALU_EN | S_A_LT | S_FLAGS | S_SUB);
    tick();
    // JC not taken, then taken
    opcode = 4'h7; flag_c = 1'b0;
    tick(); tick(); lit("jc0_t2", 3'd2, 15'h0);
    tick(); lit("jc0_wrap", 3'd0, FETCH0);
    flag_c = 1'b1;
    tick(); tick(); lit("jc1_t2", 3'd2, S_IR_EN | S_PC_LAT);
    tick(); lit("jc1_wrap", 3'd0, FETCH0);
    // JZ and OUT via model, undefined opcode as NOP
    opcode = 4'h8; flag_z = 1'b1;
    tick(); tick(); tick();
    opcode = 4'hE;
    tick(); tick(); lit("out_t2", 3'd2, S_A_EN | S_OUT);
    tick();
    opcode = 4'hA;
    tick(); tick(); lit("undef_t2", 3'd2, 15'h0);
    tick();
    // STA
    opcode = 4'h4;
    tick(); tick(); tick();
    lit("sta_t3", 3'd3, S_A_EN | S_RAM_LT);
    tick();
    // HLT
    opcode = 4'hF;
    tick(); tick(); lit("hlt_t2", 3'd2, 15'h0);
    check("hlt_pre", {31'h0, halted}, 32'h0);
    tick();
    check("hlt_set", {31'h0, halted}, 32'h1);
    for (int i = 0; i < 10; i++) begin
      tick(); lit("halted_idle", 3'd0, 15'h0);
    end
    reset = 1'b1; tick(); reset = 1'b0; #1;
    check("hlt_clear", {31'h0, halted}, 32'h0);
    lit("post_hlt_t0", 3'd0, FETCH0);
    // LDA with stall in T3
    opcode = 4'h1;
    tick(); tick(); tick();
    lit("lda_t3", 3'd3, S_RAM_EN | S_A_LT);
    run = 1'b0; #1;
    for (int i = 0; i < 3; i++) begin
      lit("stall", 3'd3, 15'h0);
      tick();
    end
    lit("stall_end", 3'd3, 15'h0);
    run = 1'b1; #1;
    lit("resume_t3", 3'd3, S_RAM_EN | S_A_LT);
    tick(); lit("resume_wrap", 3'd0, FETCH0);
    // Reset mid-ADD
    opcode = 4'h2;
    tick(); tick(); tick();
    lit("add2_t3", 3'd3, S_RAM_EN | S_B_LT);
    reset = 1'b1; #1;
    lit("rst_mid", 3'd3, 15'h0);
    tick(); reset = 1'b0; #1;
    lit("rst_release", 3'd0, FETCH0);
    tick(); lit("rst_t1", 3'd1, FETCH1);
    tick(); tick();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL timeout: simulation exceeded time limit");
    $fatal(1);
  end

endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Microcoded control unit for the 8-bit bus CPU.
- Steps through T-states T0..T4 and decodes the 4-bit opcode from the instruction register's upper nibble.
- Drives the enable/latch/inc strobes of the PC, MAR, RAM, IR, A, B, ALU and OUT registers on the shared tri-state bus.
- Sits directly upstream of every bus register. Its strobes are sampled by those registers on the next rising clk edge.

Parameters:
- STEP_W, 3, width of T-state counter (T0..T4 used).
- OP_W, 4, opcode width (IR[7:4]).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- run  in  1  1 = advance one T-state per cycle; 0 = stall (step held, all strobes 0)
- opcode  in  OP_W  IR[7:4], valid from T2 onward
- flag_c  in  1  registered ALU carry
- flag_z  in  1  registered ALU zero
- pc_en, pc_inc, pc_latch  out  1 each  program counter strobes
- mar_latch  out  1  memory address register load
- ram_en, ram_latch  out  1 each  RAM drive / write
- ir_en, ir_latch  out  1 each  IR drives low nibble to bus / IR load
- a_en, a_latch, b_latch  out  1 each  accumulator and B strobes
- alu_en, alu_sub, flags_latch  out  1 each  ALU drive, subtract select, flag capture
- out_latch  out  1  output register load
- halted  out  1  registered; 1 after HLT executes
- tstate  out  STEP_W  current T-state (debug/LED)

Behaviour:
- Reset state and reset values:
  - On reset (clk edge): step <= 0, halted <= 0.
  - While reset is high, all strobes are forced 0 combinationally.
- Strobes are a combinational function of the registered step, opcode and flags. There is no added latency: the strobe is asserted during the T-state and takes effect at that cycle's closing edge.
- Fetch, common to all opcodes:
  - T0: pc_en, mar_latch.
  - T1: ram_en, ir_latch, pc_inc.
- Execute (opcode hex):
  - 0 NOP: T2 idle.
  - 1 LDA: T2 ir_en, mar_latch; T3 ram_en, a_latch.
  - 2 ADD: T2 ir_en, mar_latch; T3 ram_en, b_latch; T4 alu_en, a_latch, flags_latch.
  - 3 SUB: same as ADD, plus alu_sub at T4.
  - 4 STA: T2 ir_en, mar_latch; T3 a_en, ram_latch.
  - 5 LDI: T2 ir_en, a_latch.
  - 6 JMP: T2 ir_en, pc_latch.
  - 7 JC: T2 ir_en, pc_latch only if flag_c = 1, else idle.
  - 8 JZ: as JC, using flag_z.
  - E OUT: T2 a_en, out_latch.
  - F HLT: T2 sets halted.
  - 9..D: undefined, executed as NOP.
- Step sequencing:
  - Last step is T4 for ADD/SUB, T3 for LDA/STA, T2 for all others.
  - At the last step, step <= 0; otherwise step <= step+1.
  - step never exceeds 4. Values 5..7 are unreachable; if forced, next step <= 0 and strobes are 0.
- Halt:
  - halted is sticky until reset.
  - While halted, step holds at 0 and all strobes are 0.
- Stall:
  - run = 0 holds step and halted and forces all strobes 0.
  - Resuming run = 1 continues at the held T-state.
- Bus invariant: at most one of pc_en, ram_en, ir_en, a_en, alu_en is high in any cycle.
- Reset mid-instruction aborts it. The next cycle after reset release is T0.
- Reset has priority over run and halted.

Decomposition:
- Shared package cpu_pkg holds:
  - opcode constants (OP_NOP..OP_HLT);
  - control-word bit-index constants;
  - ctrl_word_t typedef (16-bit packed strobe vector);
  - T-state constants T0..T4.
- Sub-module microcode_rom: combinational (opcode, step, flag_c, flag_z) -> {ctrl_word, last_step}.
- control_sequencer holds only the step counter, the halted flag and the run/reset gating.

Test Plan:
- Reset then run = 1 with opcode = 5 (LDI) -> tstate 0,1,2,0; T0 strobes pc_en|mar_latch, T1 ram_en|ir_latch|pc_inc, T2 ir_en|a_latch.
- opcode = 2 (ADD) -> 5-cycle instruction; T4 asserts alu_en|a_latch|flags_latch with alu_sub = 0; opcode = 3 gives the same with alu_sub = 1.
- opcode = 7, flag_c = 0 then 1 -> T2 strobes all 0, then ir_en|pc_latch; both return to T0 after T2.
- opcode = F -> halted = 1 one edge after T2; 10 further cycles show tstate = 0 and all strobes 0; reset clears halted.
- run dropped during T3 of LDA for 3 cycles -> tstate stays 3 with strobes 0; on resume, T3 strobes ram_en|a_latch, then T0.
- reset pulsed at T3 of ADD -> strobes 0 during reset, next cycle tstate = 0 with fetch strobes; bus-invariant assertion checked every cycle.
